cfg_bus_master: RTL



---
 rtl/cfg_bus_master_pkg.sv | 25 ++
 rtl/cfg_bus_if.sv | 12 +
 rtl/cfg_bus_master_timeout.sv | 18 +
 rtl/cfg_bus_master.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cfg_bus_master_pkg.sv
// cfg_bus_master_pkg: shared widths, slot addresses, UART line-format encodings, bus data codes and FSM states
package cfg_bus_master_pkg;
   localparam int WIDTH_CONFIG_ADDR = 2;
   localparam int WIDTH_CONFIG_DATA = 8;
   localparam logic [1:0] SLOT_UART = 2'b01;
   localparam logic [1:0] SLOT_VGA  = 2'b10;
   localparam logic [1:0] PAR_NONE    = 2'b00;
   localparam logic [1:0] PAR_ILLEGAL = 2'b01;
   localparam logic [1:0] PAR_EVEN    = 2'b10;
   localparam logic [1:0] PAR_ODD     = 2'b11;
   localparam logic STOP_1 = 1'b0;
   localparam logic STOP_2 = 1'b1;
   localparam logic [4:0] CODE_PAR_NONE = 5'b01000;
   localparam logic [4:0] CODE_PAR_ODD  = 5'b01001;
   localparam logic [4:0] CODE_PAR_EVEN = 5'b01010;
   localparam logic [4:0] CODE_STOP_1   = 5'b10000;
   localparam logic [4:0] CODE_STOP_2   = 5'b10001;
   typedef enum logic [1:0] {ST_IDLE, ST_QUIET, ST_ISSUE, ST_DONE} state_t;
   function automatic logic [4:0] parity_code(input logic [1:0] p);
      return p == PAR_ODD ? CODE_PAR_ODD : p == PAR_EVEN ? CODE_PAR_EVEN : CODE_PAR_NONE;
   endfunction
   function automatic logic [4:0] stop_code(input logic s);
      return s == STOP_2 ? CODE_STOP_2 : CODE_STOP_1;
   endfunction
endpackage

// File: rtl/cfg_bus_if.sv
// cfg_bus_if: shared configuration bus (address, write valid, data, responder ready)
interface cfg_bus_if #(
   parameter int WIDTH_CONFIG_ADDR = cfg_bus_master_pkg::WIDTH_CONFIG_ADDR,
   parameter int WIDTH_CONFIG_DATA = cfg_bus_master_pkg::WIDTH_CONFIG_DATA
);
   logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
   logic                         c_valid;
   logic [WIDTH_CONFIG_DATA-1:0] c_data;
   logic                         c_ready;
   modport master (output c_addr, c_valid, c_data, input c_ready);
   modport slave  (input c_addr, c_valid, c_data, output c_ready);
endinterface

// File: rtl/cfg_bus_master_timeout.sv
// cfg_timeout_counter: per-phase wait counter, flags expiry at TIMEOUT_CYCLES-1
module cfg_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYCLES);
   logic [W-1:0] cnt;
   assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
   // count while enabled, saturating at expiry; clear restarts the window
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cfg_bus_master.sv
// cfg_bus_master: turns a UART line-format request into parity then stop-bit writes on the config bus; CFG_SKIP_UNCHANGED_EN skips phases matching the last acknowledged codes
module cfg_bus_master
   import cfg_bus_master_pkg::*;
#(
   parameter int WIDTH_CONFIG_ADDR = cfg_bus_master_pkg::WIDTH_CONFIG_ADDR,
   parameter int WIDTH_CONFIG_DATA = cfg_bus_master_pkg::WIDTH_CONFIG_DATA,
   parameter int TIMEOUT_CYCLES = 64,
   parameter logic [WIDTH_CONFIG_ADDR-1:0] UART_SLOT_ADDR = WIDTH_CONFIG_ADDR'(SLOT_UART)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_parity,
   input  logic             req_stop,
   cfg_bus_if.master        bus,
   output logic             busy,
   output logic             done,
   output logic             err
);
   state_t     state;
   logic       phase;
   logic [1:0] par_q;
   logic       stop_q;
   logic       expired;
   logic       active;
   logic       adv;
   logic [4:0] cur_code;
   logic       skip_par;
   logic       skip_stop_req;
   logic       skip_stop_lat;
   assign req_ready = state == ST_IDLE;
   assign busy      = state != ST_IDLE;
   assign active    = state == ST_QUIET || state == ST_ISSUE;
   assign adv       = (state == ST_QUIET && !bus.c_ready) || (state == ST_ISSUE && bus.c_ready);
   assign cur_code  = phase ? stop_code(stop_q) : parity_code(par_q);
   cfg_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (!active || adv),
      .en      (active),
      .expired (expired)
   );
`ifdef CFG_SKIP_UNCHANGED_EN
   logic [4:0] sh_par;
   logic [4:0] sh_stop;
   assign skip_par      = parity_code(req_parity) == sh_par;
   assign skip_stop_req = stop_code(req_stop) == sh_stop;
   assign skip_stop_lat = stop_code(stop_q) == sh_stop;
   // shadows track what the responder actually acknowledged
   always_ff @(posedge clk)
      if (rst) begin
         sh_par  <= CODE_PAR_NONE;
         sh_stop <= CODE_STOP_1;
      end else if (state == ST_ISSUE && bus.c_ready) begin
         if (phase) sh_stop <= cur_code;
         else sh_par <= cur_code;
      end
`else
   assign skip_par      = 1'b0;
   assign skip_stop_req = 1'b0;
   assign skip_stop_lat = 1'b0;
`endif
   // request sequencer with registered bus and status outputs
   always_ff @(posedge clk)
      if (rst) begin
         state       <= ST_IDLE;
         phase       <= 1'b0;
         par_q       <= PAR_NONE;
         stop_q      <= STOP_1;
         bus.c_valid <= 1'b0;
         bus.c_addr  <= '0;
         bus.c_data  <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE:
               if (req_valid) begin
                  par_q  <= req_parity;
                  stop_q <= req_stop;
                  err    <= req_parity == PAR_ILLEGAL;
                  if (req_parity == PAR_ILLEGAL) done <= 1'b1;
                  else if (skip_par && skip_stop_req) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_QUIET;
                     phase <= skip_par;
                  end
               end
            ST_QUIET:
               if (!bus.c_ready) begin
                  state       <= ST_ISSUE;
                  bus.c_valid <= 1'b1;
                  bus.c_addr  <= UART_SLOT_ADDR;
                  bus.c_data  <= WIDTH_CONFIG_DATA'({cur_code, 2'b00});
               end else if (expired) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end
            ST_ISSUE:
               if (bus.c_ready || expired) begin
                  bus.c_valid <= 1'b0;
                  bus.c_addr  <= '0;
                  bus.c_data  <= '0;
                  if (!bus.c_ready || phase || skip_stop_lat) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= !bus.c_ready;
                  end else begin
                     state <= ST_QUIET;
                     phase <= 1'b1;
                  end
               end
            default: begin
               state <= ST_IDLE;
               phase <= 1'b0;
            end
         endcase
      end
endmodule
